// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter between the SDRAM init, auto-refresh, write
// and read engines. Sole driver of the SDRAM command/address/data pins.
// Refresh has top priority; write and read alternate when both are pending.
module sdram_arbit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned BA_W    = 2,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              clk,
  input  logic              rst,
  // initialisation engine
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_bank_addr,
  input  logic [ADDR_W-1:0] init_addr,
  // auto-refresh engine
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  // write engine
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_bank_addr,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              wr_sdram_en,
  // read engine
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_bank_addr,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  // grants
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  // SDRAM pins
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_bank_addr,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  // Which of write/read owned the bus most recently; the other wins a tie.
  typedef enum logic {
    RR_WRITE,
    RR_READ
  } rr_t;

  state_t state_q, state_d;
  rr_t    rr_last_q, rr_last_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;

  // Next-state and grant logic; grants are registered alongside the state.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_end) begin
          state_d = ST_ARBIT;
        end
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_d   = ST_AREF;
          aref_en_d = 1'b1;
        end else if (wr_req && rd_req) begin
          if (rr_last_q == RR_READ) begin
            state_d = ST_WRITE;
            wr_en_d = 1'b1;
          end else begin
            state_d = ST_READ;
            rd_en_d = 1'b1;
          end
        end else if (wr_req) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_AREF: begin
        if (aref_end) begin
          state_d   = ST_ARBIT;
          aref_en_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (wr_end) begin
          state_d   = ST_ARBIT;
          wr_en_d   = 1'b0;
          rr_last_d = RR_WRITE;
        end
      end
      ST_READ: begin
        if (rd_end) begin
          state_d   = ST_ARBIT;
          rd_en_d   = 1'b0;
          rr_last_d = RR_READ;
        end
      end
      default: begin
        state_d   = ST_INIT;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  // State, round-robin pointer and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      rr_last_q <= RR_READ;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // Pin mux: combinational from the registered owner, no pipeline stage.
  always_comb begin
    sdram_cmd       = CMD_NOP;
    sdram_bank_addr = '0;
    sdram_addr      = '0;
    sdram_dq_out    = '0;
    sdram_dq_oe     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        sdram_cmd       = init_cmd;
        sdram_bank_addr = init_bank_addr;
        sdram_addr      = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd       = wr_cmd;
        sdram_bank_addr = wr_bank_addr;
        sdram_addr      = wr_sdram_addr;
        sdram_dq_out    = wr_sdram_data;
        sdram_dq_oe     = wr_sdram_en;
      end
      ST_READ: begin
        sdram_cmd       = rd_cmd;
        sdram_bank_addr = rd_bank_addr;
        sdram_addr      = rd_sdram_addr;
      end
      default: begin
        sdram_cmd = CMD_NOP;
      end
    endcase
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = 1'b1;

endmodule
